alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// master = environment (requesters, response sinks, ALU core); slave = arbiter.
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [6:0]  req0_opcode, req1_opcode;
  logic [2:0]  req0_funct3, req1_funct3;
  logic        req0_funct7_5, req1_funct7_5;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;

  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [63:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;

  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7_5;
  logic [63:0] alu_a, alu_b;
  logic [63:0] alu_result;
  logic        alu_zero;

  logic        busy;
  logic        grant_id;
  logic [15:0] ops_done;

  modport master (
    output req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_funct3, req1_funct3, req0_funct7_5, req1_funct7_5,
           req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
           alu_opcode, alu_funct3, alu_funct7_5, alu_a, alu_b,
           busy, grant_id, ops_done
  );

  modport slave (
    input  req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_funct3, req1_funct3, req0_funct7_5, req1_funct7_5,
           req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
           alu_opcode, alu_funct3, alu_funct7_5, alu_a, alu_b,
           busy, grant_id, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one combinational ALU core.
// One operation in flight: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold until taken).
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        rr_ptr;
  logic        grant_q;
  logic [15:0] ops_cnt;

  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic        funct7_5_q;
  logic [63:0] a_q, b_q;

  logic [63:0] rsp0_result_q, rsp1_result_q;
  logic        rsp0_zero_q, rsp1_zero_q;
  logic        rsp0_valid_q, rsp1_valid_q;

  logic        pick;
  logic        accept;
  logic        rsp_taken;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick = rr_ptr;
    if (bus.req0_valid && !bus.req1_valid) pick = 1'b0;
    else if (!bus.req0_valid && bus.req1_valid) pick = 1'b1;
  end

  // Ready is gated with rst_n so it reads zero while reset is held.
  assign accept         = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !pick;
  assign bus.req1_ready = accept && pick;
  assign rsp_taken      = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      grant_q       <= 1'b0;
      ops_cnt       <= 16'h0000;
      // NOTE: datapath registers are reset too, so a reset leaves every output at a known zero.
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_5_q    <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_q    <= pick;
            opcode_q   <= pick ? bus.req1_opcode   : bus.req0_opcode;
            funct3_q   <= pick ? bus.req1_funct3   : bus.req0_funct3;
            funct7_5_q <= pick ? bus.req1_funct7_5 : bus.req0_funct7_5;
            a_q        <= pick ? bus.req1_a        : bus.req0_a;
            b_q        <= pick ? bus.req1_b        : bus.req0_b;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (grant_q) begin
            rsp1_result_q <= bus.alu_result;
            rsp1_zero_q   <= bus.alu_zero;
            rsp1_valid_q  <= 1'b1;
          end else begin
            rsp0_result_q <= bus.alu_result;
            rsp0_zero_q   <= bus.alu_zero;
            rsp0_valid_q  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rr_ptr       <= ~grant_q;
            ops_cnt      <= ops_cnt + 16'h0001;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_opcode   = opcode_q;
  assign bus.alu_funct3   = funct3_q;
  assign bus.alu_funct7_5 = funct7_5_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;

  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp0_result  = rsp0_result_q;
  assign bus.rsp1_result  = rsp1_result_q;
  assign bus.rsp0_zero    = rsp0_zero_q;
  assign bus.rsp1_zero    = rsp1_zero_q;

  assign bus.busy         = (state != IDLE);
  assign bus.grant_id     = grant_q;
  assign bus.ops_done     = ops_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the bench also plays the shared ALU core.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] OP_R = 7'b0110011;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference ALU core, combinational on the arbiter's alu_* outputs.
  always_comb begin
    case (bus.alu_funct3)
      3'b000:  bus.alu_result = bus.alu_funct7_5 ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
      3'b100:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b110:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b111:  bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = 64'h0;
    endcase
    bus.alu_zero = (bus.alu_result == 64'h0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_opcode = 0; bus.req1_opcode = 0;
    bus.req0_funct3 = 0; bus.req1_funct3 = 0;
    bus.req0_funct7_5 = 0; bus.req1_funct7_5 = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;

    // Reset state
    step(); step();
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant_id, 0);
    check("rst_ops", bus.ops_done, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_alu_a", bus.alu_a, 0);
    rst_n = 1'b1;
    step();

    // Single ADD on req0
    bus.req0_valid = 1; bus.req0_opcode = OP_R; bus.req0_funct3 = 3'b000; bus.req0_funct7_5 = 0;
    bus.req0_a = 64'd10; bus.req0_b = 64'd5; bus.rsp0_ready = 1;
    #1;
    check("single_req0_ready", bus.req0_ready, 1);
    check("single_req1_ready", bus.req1_ready, 0);
    step();
    bus.req0_valid = 0;
    #1;
    check("single_exec_busy", bus.busy, 1);
    check("single_alu_opcode", bus.alu_opcode, OP_R);
    check("single_alu_a", bus.alu_a, 64'd10);
    check("single_exec_rsp_valid", bus.rsp0_valid, 0);
    check("single_exec_ready", bus.req0_ready, 0);
    step();
    check("single_rsp_valid", bus.rsp0_valid, 1);
    check("single_result", bus.rsp0_result, 64'd15);
    check("single_zero", bus.rsp0_zero, 0);
    step();
    check("single_rsp_drop", bus.rsp0_valid, 0);
    check("single_idle", bus.busy, 0);
    check("single_ops", bus.ops_done, 1);

    // Reset again so contention starts from rr_ptr=0
    rst_n = 0; step(); rst_n = 1; step();

    // Contention: req0 SUB, req1 AND, both valid
    bus.req0_valid = 1; bus.req0_funct3 = 3'b000; bus.req0_funct7_5 = 1;
    bus.req0_a = 64'd10; bus.req0_b = 64'd5;
    bus.req1_valid = 1; bus.req1_opcode = OP_R; bus.req1_funct3 = 3'b111; bus.req1_funct7_5 = 0;
    bus.req1_a = 64'hFF00; bus.req1_b = 64'h0F0F;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    #1;
    check("cont_req0_ready", bus.req0_ready, 1);
    check("cont_req1_ready", bus.req1_ready, 0);
    step();
    bus.req0_valid = 0;
    #1;
    check("cont_grant0", bus.grant_id, 0);
    check("cont_alu_f7", bus.alu_funct7_5, 1);
    check("cont_req1_stall", bus.req1_ready, 0);
    step();
    check("cont_rsp0_valid", bus.rsp0_valid, 1);
    check("cont_rsp0_result", bus.rsp0_result, 64'd5);
    check("cont_rsp1_quiet", bus.rsp1_valid, 0);
    step();
    check("cont_req1_ready_now", bus.req1_ready, 1);
    step();
    bus.req1_valid = 0;
    #1;
    check("cont_grant1", bus.grant_id, 1);
    check("cont_alu_f3", bus.alu_funct3, 3'b111);
    step();
    check("cont_rsp1_valid", bus.rsp1_valid, 1);
    check("cont_rsp1_result", bus.rsp1_result, 64'h0F00);
    check("cont_rsp0_retain", bus.rsp0_result, 64'd5);
    check("cont_rsp0_invalid", bus.rsp0_valid, 0);
    step();
    check("cont_ops", bus.ops_done, 2);

    // Fairness: both valid for 6 operations
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("fair_ready0_%0d", i), bus.req0_ready, ((i % 2) == 0));
      step();
      check($sformatf("fair_grant_%0d", i), bus.grant_id, i % 2);
      step();
      step();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    check("fair_ops", bus.ops_done, 8);

    // Backpressure: req1 SUB 7-7 with rsp1_ready low
    bus.req1_valid = 1; bus.req1_funct3 = 3'b000; bus.req1_funct7_5 = 1;
    bus.req1_a = 64'd7; bus.req1_b = 64'd7; bus.rsp1_ready = 0;
    #1;
    check("bp_req1_ready", bus.req1_ready, 1);
    step();
    bus.req1_valid = 0;
    bus.req0_valid = 1; bus.req0_funct3 = 3'b000; bus.req0_funct7_5 = 0;
    bus.req0_a = 64'd1; bus.req0_b = 64'd2;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), bus.rsp1_valid, 1);
      check($sformatf("bp_result_%0d", i), bus.rsp1_result, 0);
      check($sformatf("bp_zero_%0d", i), bus.rsp1_zero, 1);
      check($sformatf("bp_req0_stall_%0d", i), bus.req0_ready, 0);
      step();
    end
    bus.rsp1_ready = 1;
    step();
    check("bp_rsp1_drop", bus.rsp1_valid, 0);
    check("bp_ops", bus.ops_done, 9);
    check("bp_req0_not_lost", bus.req0_ready, 1);
    step();
    bus.req0_valid = 0;
    #1;
    check("bp_req0_exec", bus.alu_a, 64'd1);

    // Reset during EXEC abandons the operation
    rst_n = 0;
    #1;
    check("rmid_busy", bus.busy, 0);
    check("rmid_grant", bus.grant_id, 0);
    check("rmid_ops", bus.ops_done, 0);
    check("rmid_alu_a", bus.alu_a, 0);
    check("rmid_alu_opcode", bus.alu_opcode, 0);
    check("rmid_rsp1_result", bus.rsp1_result, 0);
    check("rmid_rsp1_zero", bus.rsp1_zero, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rmid_no_rsp0_%0d", i), bus.rsp0_valid, 0);
      check($sformatf("rmid_no_rsp1_%0d", i), bus.rsp1_valid, 0);
    end
    check("rmid_ops_after", bus.ops_done, 0);

    // Wrap: preload the counter to 0xFFFF, complete one op
    force dut.ops_cnt = 16'hFFFF;
    #1;
    release dut.ops_cnt;
    #1;
    check("wrap_preload", bus.ops_done, 16'hFFFF);
    bus.req0_valid = 1; bus.req0_funct3 = 3'b110; bus.req0_funct7_5 = 0;
    bus.req0_a = 64'hF0; bus.req0_b = 64'h0F; bus.rsp0_ready = 1;
    step();
    bus.req0_valid = 0;
    step();
    check("wrap_or_result", bus.rsp0_result, 64'hFF);
    step();
    check("wrap_ops", bus.ops_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
